// File: rtl/pwm_duty_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_ramp_ctrl
// Description : Ramps the live PWM duty cycle toward a programmed target in
//               fixed steps at a programmable interval, with busy/done status.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ramp_ctrl #(
    parameter int         INTERVAL_W = 16,
    parameter logic [7:0] RESET_DUTY = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [7:0]            cfg_target,
    input  logic [7:0]            cfg_step,
    input  logic [INTERVAL_W-1:0] cfg_interval,
    input  logic                  hold,
    output logic [7:0]            duty_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam logic [INTERVAL_W-1:0] c_cnt_one = {{(INTERVAL_W-1){1'b0}}, 1'b1};

    state_t                r_state,    w_state_nxt;
    logic [7:0]            r_target,   w_target_nxt;
    logic [7:0]            r_step,     w_step_nxt;
    logic [7:0]            r_duty,     w_duty_nxt;
    logic [INTERVAL_W-1:0] r_interval, w_interval_nxt;
    logic [INTERVAL_W-1:0] r_cnt,      w_cnt_nxt;
    logic                  r_done,     w_done_nxt;

    logic                  w_up;
    logic [8:0]            w_diff;

    // Distance to target is taken as a 9-bit unsigned magnitude so the clamp
    // test can never be fooled by wrap-around.
    always_comb begin
        w_up   = (r_target > r_duty);
        w_diff = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                      : ({1'b0, r_duty}   - {1'b0, r_target});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_target   <= RESET_DUTY;
            r_step     <= 8'h00;
            r_duty     <= RESET_DUTY;
            r_interval <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_step     <= w_step_nxt;
            r_duty     <= w_duty_nxt;
            r_interval <= w_interval_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_step_nxt     = r_step;
        w_duty_nxt     = r_duty;
        w_interval_nxt = r_interval;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;

        if (cfg_valid) begin
            // A new configuration always wins over a step due on this edge.
            w_target_nxt   = cfg_target;
            w_step_nxt     = cfg_step;
            w_interval_nxt = cfg_interval;
            w_cnt_nxt      = cfg_interval;
            if (cfg_target == r_duty) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else if (cfg_step == 8'h00) begin
                w_duty_nxt  = cfg_target;
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_RAMP;
            end
        end else if ((r_state == ST_RAMP) && !hold) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - c_cnt_one;
            end else begin
                w_cnt_nxt = r_interval;
                if (w_diff <= {1'b0, r_step}) begin
                    w_duty_nxt  = r_target;
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_up) begin
                    w_duty_nxt = r_duty + r_step;
                end else begin
                    w_duty_nxt = r_duty - r_step;
                end
            end
        end
    end

    assign duty_out = r_duty;
    assign busy     = (r_state == ST_RAMP);
    assign done     = r_done;

endmodule
`default_nettype wire
